ddr4_bringup_seq: RTL
=====================

// Module: ddr4_bringup_seq
// PURPOSE
//  Sequences DDR4 daughtercard bring-up: power rails VCC2V5->VDDQ->VTT, power_good check, MIG sys_rst, calibration.
//  Retries failed calibration, then reports ready or fault to the SoC.
//  Sits in the FPGA top between the board power pins, the MIG (sys_rst / init_calib_complete) and SoC status.
// PARAMETERS
//  RailDelayCycles  default 4800     clk cycles between successive rail enables (100us @48MHz)
//  PgTimeoutCycles  default 480000   max cycles waiting for power_good after VTT enable
//  RstHoldCycles    default 64       cycles mig_rst_o held high in MIG_RST
//  CalTimeoutCycles default 48000000 max cycles waiting for calib complete per attempt
//  MaxRetries       default 3        calibration re-attempts before FAULT (0 = single attempt)
// PORTS
//  clk_i            in  1  sequencer clock (free-running board-derived clock)
//  rst_ni           in  1  asynchronous active-low reset
//  enable_i         in  1  level; 1 = bring DDR up, 0 = power down
//  power_good_i     in  1  board rail power-good, async (synchronized inside)
//  calib_complete_i in  1  MIG init_calib_complete, ui_clk domain (synchronized inside)
//  en_vcc2v5_o      out 1  VCC2V5 rail enable
//  en_vddq_o        out 1  VDDQ rail enable
//  en_vtt_o         out 1  VTT rail enable
//  mig_rst_o        out 1  MIG sys_rst, active-high
//  ready_o          out 1  DDR usable
//  fault_o          out 1  bring-up failed or lost
//  state_o          out 4  current state encoding (debug)
//  retry_cnt_o      out 2  calibration attempts failed so far, saturating
// BEHAVIOUR
//  Reset: state OFF; all en_* = 0, mig_rst_o = 1, ready_o = 0, fault_o = 0, retry_cnt_o = 0, timer = 0.
//  power_good_i and calib_complete_i pass 2-flop synchronizers: 2-cycle input latency.
//  All outputs are registered and decoded from state (Moore). Timer reloads to 0 on every state change.
//  States / transitions:
//   OFF:      enable_i=1 -> VCC; retry_cnt cleared.
//   VCC:      en_vcc2v5. Timer==RailDelayCycles-1 -> VDDQ.
//   VDDQ:     +en_vddq. Timer==RailDelayCycles-1 -> VTT.
//   VTT:      +en_vtt. pg_sync=1 -> MIG_RST; timer==PgTimeoutCycles-1 -> FAULT.
//   MIG_RST:  rails on, mig_rst=1. Timer==RstHoldCycles-1 -> CAL_WAIT.
//   CAL_WAIT: mig_rst=0. cal_sync=1 -> READY. Timer==CalTimeoutCycles-1: retry_cnt<MaxRetries -> MIG_RST, retry_cnt+1; else FAULT.
//   READY:    ready_o=1. pg_sync=0 or cal_sync=0 -> FAULT.
//   FAULT:    all rails off, mig_rst=1, fault_o=1. Sticky until enable_i=0 -> OFF.
//  enable_i=0 in any state: next cycle -> OFF, all rails off at once; highest priority.
//  In CAL_WAIT, cal_sync=1 wins over a timeout in the same cycle.
//  In VTT, pg_sync=1 wins over a timeout in the same cycle.
//  pg_sync=0 in MIG_RST or CAL_WAIT -> FAULT.
//  Timer: 32-bit up-counter, saturates at all-ones. Never wraps.
//  retry_cnt_o saturates at 3 regardless of MaxRetries.
//  Async reset mid-sequence: outputs return to reset values immediately (rails drop).
// CONFIGURATION
//  DDR4_BRINGUP_CAL_CYCLES_EN defined:
//   - Adds output cal_cycles_o [31:0]: cycles spent in the last CAL_WAIT ending in READY.
//   - Latched on the CAL_WAIT->READY transition; reset 0; saturating.
//  DDR4_BRINGUP_CAL_CYCLES_EN undefined: port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  ddr4_bringup_pkg:
//   - state_e enum: OFF=0, VCC, VDDQ, VTT, MIG_RST, CAL_WAIT, READY, FAULT.
//   - TimerWidth=32 constant.
//  Sub-module ddr4_bringup_sync: parameterized 2-flop synchronizer with async active-low reset.
//   - Reset value 0; instantiated twice.
// TESTING (RailDelay=4, PgTimeout=20, RstHold=3, CalTimeout=10, MaxRetries=1)
//  1. enable=1, power_good high at VTT+5, calib high 6 cycles after mig_rst falls:
//     - en_vcc2v5, en_vddq, en_vtt rise 4 cycles apart.
//     - mig_rst_o high 3 cycles, then falls.
//     - ready_o=1 within 3 cycles of calib; with macro, cal_cycles_o=8.
//  2. power_good never rises:
//     - FAULT 20 cycles after VTT entry; fault_o=1, all rails 0.
//     - enable=0 -> OFF; fault_o=0.
//  3. calib never rises:
//     - Two CAL_WAIT windows; retry_cnt_o=1 after the first.
//     - mig_rst_o re-pulses 3 cycles between windows; then FAULT.
//  4. calib rises in the second attempt:
//     - READY with retry_cnt_o=1.
//     - Later deassert power_good -> FAULT; ready_o=0 within 3 cycles.
//  5. enable=0 mid-VDDQ:
//     - Next cycle state OFF, rails 0, mig_rst 1.
//     - Re-enable restarts from VCC with timer=0.
//  6. Assert rst_ni low in READY: outputs go to reset values asynchronously, without a clock edge.

Source files
------------

// File: rtl/ddr4_bringup_pkg.sv
// ============================================================================
//  Module : ddr4_bringup_pkg
//  Brief  : Shared state encodings, timer width and rail decode for the DDR4 bring-up sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ddr4_bringup_pkg;

  localparam int TIMER_WIDTH = 32;

  typedef enum logic [3:0] {
    OFF      = 4'd0,
    VCC      = 4'd1,
    VDDQ     = 4'd2,
    VTT      = 4'd3,
    MIG_RST  = 4'd4,
    CAL_WAIT = 4'd5,
    READY    = 4'd6,
    FAULT    = 4'd7
  } state_e;

  // Plain-vector aliases so the state register stays a logic [3:0] in the sequencer
  localparam logic [3:0] ST_OFF      = OFF;
  localparam logic [3:0] ST_VCC      = VCC;
  localparam logic [3:0] ST_VDDQ     = VDDQ;
  localparam logic [3:0] ST_VTT      = VTT;
  localparam logic [3:0] ST_MIG_RST  = MIG_RST;
  localparam logic [3:0] ST_CAL_WAIT = CAL_WAIT;
  localparam logic [3:0] ST_READY    = READY;
  localparam logic [3:0] ST_FAULT    = FAULT;

  // Rail enables {vcc2v5, vddq, vtt} implied by a state
  function automatic logic [2:0] rail_mask(input logic [3:0] st);
    logic [2:0] mask;
    mask = 3'b000;
    case (st)
      ST_VCC:      mask = 3'b100;
      ST_VDDQ:     mask = 3'b110;
      ST_VTT,
      ST_MIG_RST,
      ST_CAL_WAIT,
      ST_READY:    mask = 3'b111;
      default:     mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr4_bringup_if.sv
// ============================================================================
//  Module : ddr4_bringup_if
//  Brief  : Board power / MIG / SoC status signals of the bring-up sequencer.
//           DDR4_BRINGUP_CAL_CYCLES_EN adds cal_cycles_o.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ddr4_bringup_if;
  import ddr4_bringup_pkg::*;

  logic                   enable_i;
  logic                   power_good_i;
  logic                   calib_complete_i;
  logic                   en_vcc2v5_o;
  logic                   en_vddq_o;
  logic                   en_vtt_o;
  logic                   mig_rst_o;
  logic                   ready_o;
  logic                   fault_o;
  logic [3:0]             state_o;
  logic [1:0]             retry_cnt_o;
`ifdef DDR4_BRINGUP_CAL_CYCLES_EN
  logic [TIMER_WIDTH-1:0] cal_cycles_o;
`endif

  modport master (
    input  enable_i,
    input  power_good_i,
    input  calib_complete_i,
    output en_vcc2v5_o,
    output en_vddq_o,
    output en_vtt_o,
    output mig_rst_o,
    output ready_o,
    output fault_o,
    output state_o,
    output retry_cnt_o
`ifdef DDR4_BRINGUP_CAL_CYCLES_EN
    , output cal_cycles_o
`endif
  );

  modport slave (
    output enable_i,
    output power_good_i,
    output calib_complete_i,
    input  en_vcc2v5_o,
    input  en_vddq_o,
    input  en_vtt_o,
    input  mig_rst_o,
    input  ready_o,
    input  fault_o,
    input  state_o,
    input  retry_cnt_o
`ifdef DDR4_BRINGUP_CAL_CYCLES_EN
    , input cal_cycles_o
`endif
  );

endinterface

`default_nettype wire

// File: rtl/ddr4_bringup_sync.sv
// ============================================================================
//  Module : ddr4_bringup_sync
//  Brief  : Two-flop synchronizer, async active-low reset to zero.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ddr4_bringup_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

`default_nettype wire

// File: rtl/ddr4_bringup_seq.sv
// ============================================================================
//  Module : ddr4_bringup_seq
//  Brief  : DDR4 card bring-up: rails VCC2V5->VDDQ->VTT, power-good, MIG reset,
//           calibration with retries. DDR4_BRINGUP_CAL_CYCLES_EN adds cal_cycles_o.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ddr4_bringup_seq
  import ddr4_bringup_pkg::*;
#(
  parameter int unsigned RAIL_DELAY_CYCLES  = 4800,
  parameter int unsigned PG_TIMEOUT_CYCLES  = 480000,
  parameter int unsigned RST_HOLD_CYCLES    = 64,
  parameter int unsigned CAL_TIMEOUT_CYCLES = 48000000,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ddr4_bringup_if.master bus
);

  localparam logic [TIMER_WIDTH-1:0] c_rail_last = TIMER_WIDTH'(RAIL_DELAY_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] c_pg_last   = TIMER_WIDTH'(PG_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] c_rst_last  = TIMER_WIDTH'(RST_HOLD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] c_cal_last  = TIMER_WIDTH'(CAL_TIMEOUT_CYCLES - 1);

  logic                   w_pg_sync;
  logic                   w_cal_sync;
  logic [3:0]             r_state;
  logic [3:0]             w_state_next;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [1:0]             r_retry_cnt;
  logic                   w_retry_inc;
  logic                   w_retry_ok;
  logic [2:0]             r_rails;
  logic                   r_mig_rst;
  logic                   r_ready;
  logic                   r_fault;

  ddr4_bringup_sync #(.WIDTH(1)) u_pg_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.power_good_i),
    .q_o    (w_pg_sync)
  );

  ddr4_bringup_sync #(.WIDTH(1)) u_cal_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.calib_complete_i),
    .q_o    (w_cal_sync)
  );

  assign w_retry_ok = ({30'd0, r_retry_cnt} < MAX_RETRIES);

  always_comb begin
    w_state_next = r_state;
    w_retry_inc  = 1'b0;
    if (!bus.enable_i) begin
      w_state_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:  w_state_next = ST_VCC;
        ST_VCC:  if (r_timer == c_rail_last) w_state_next = ST_VDDQ;
        ST_VDDQ: if (r_timer == c_rail_last) w_state_next = ST_VTT;
        ST_VTT: begin
          if (w_pg_sync)                 w_state_next = ST_MIG_RST;
          else if (r_timer == c_pg_last) w_state_next = ST_FAULT;
        end
        ST_MIG_RST: begin
          if (!w_pg_sync)                 w_state_next = ST_FAULT;
          else if (r_timer == c_rst_last) w_state_next = ST_CAL_WAIT;
        end
        ST_CAL_WAIT: begin
          // Completion beats a coincident timeout; power loss beats both
          if (!w_pg_sync) begin
            w_state_next = ST_FAULT;
          end else if (w_cal_sync) begin
            w_state_next = ST_READY;
          end else if (r_timer == c_cal_last) begin
            if (w_retry_ok) begin
              w_state_next = ST_MIG_RST;
              w_retry_inc  = 1'b1;
            end else begin
              w_state_next = ST_FAULT;
            end
          end
        end
        ST_READY: if (!w_pg_sync || !w_cal_sync) w_state_next = ST_FAULT;
        ST_FAULT: w_state_next = ST_FAULT;
        default:  w_state_next = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_OFF;
      r_timer     <= '0;
      r_retry_cnt <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_timer <= '0;
      end else if (r_timer != {TIMER_WIDTH{1'b1}}) begin
        r_timer <= r_timer + 1'b1;
      end
      if (r_state == ST_OFF && w_state_next == ST_VCC) begin
        r_retry_cnt <= 2'd0;
      end else if (w_retry_inc && r_retry_cnt != 2'd3) begin
        r_retry_cnt <= r_retry_cnt + 2'd1;
      end
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state_o
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rails   <= 3'b000;
      r_mig_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_rails   <= rail_mask(w_state_next);
      r_mig_rst <= !(w_state_next == ST_CAL_WAIT || w_state_next == ST_READY);
      r_ready   <= (w_state_next == ST_READY);
      r_fault   <= (w_state_next == ST_FAULT);
    end
  end

`ifdef DDR4_BRINGUP_CAL_CYCLES_EN
  logic [TIMER_WIDTH-1:0] r_cal_cycles;

  // Timer already saturates, so the latched value does too
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cal_cycles <= '0;
    end else if (r_state == ST_CAL_WAIT && w_state_next == ST_READY) begin
      r_cal_cycles <= r_timer;
    end
  end

  assign bus.cal_cycles_o = r_cal_cycles;
`endif

  assign bus.en_vcc2v5_o = r_rails[2];
  assign bus.en_vddq_o   = r_rails[1];
  assign bus.en_vtt_o    = r_rails[0];
  assign bus.mig_rst_o   = r_mig_rst;
  assign bus.ready_o     = r_ready;
  assign bus.fault_o     = r_fault;
  assign bus.state_o     = r_state;
  assign bus.retry_cnt_o = r_retry_cnt;

endmodule

`default_nettype wire
